// File: rtl/ternary_pkg.sv
// ---------------------------------------------------------------------------
// ternary_pkg
// Shared definitions for the ternary matrix-vector sequencer:
//   - datapath geometry and the derived load-beat count / index widths
//   - 2-bit command encodings
//   - sequencer state enum
// No ports (package).
// ---------------------------------------------------------------------------
package ternary_pkg;

    localparam int MAX_IN_LEN  = 16;  // weights per row
    localparam int MAX_OUT_LEN = 8;   // output rows, power of 2
    localparam int BUS_WIDTH   = 16;  // input bus width

    // Two bits per ternary weight, streamed over the input bus.
    localparam int LD_BEATS = 2 * MAX_IN_LEN * MAX_OUT_LEN / BUS_WIDTH;

    localparam int LD_IDX_W = $clog2(LD_BEATS);
    localparam int ROW_W    = $clog2(MAX_OUT_LEN);

    typedef enum logic [1:0] {
        CMD_NOP       = 2'b00,
        CMD_LOAD_ONLY = 2'b01,
        CMD_LOAD_MULT = 2'b10,
        CMD_MULT      = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_MULT,
        S_DONE
    } state_e;

endpackage

// File: rtl/ternary_mac_sequencer_if.sv
// ---------------------------------------------------------------------------
// ternary_mac_sequencer_if
// Command and status bundle of the ternary MAC sequencer.
//   master : host side - drives cmd_valid/cmd/abort/mult_cont, reads status
//   slave  : sequencer side - the reverse
// Signals:
//   cmd_valid, cmd[1:0], abort, mult_cont   host -> sequencer
//   cmd_ready, ld_en, ld_idx, wt_valid,     sequencer -> host / datapath
//   mult_en, row, row_last, busy, done, err
// ---------------------------------------------------------------------------
interface ternary_mac_sequencer_if;
    import ternary_pkg::*;

    logic                cmd_valid;
    logic [1:0]          cmd;
    logic                abort;
    logic                mult_cont;

    logic                cmd_ready;
    logic                ld_en;
    logic [LD_IDX_W-1:0] ld_idx;
    logic                wt_valid;
    logic                mult_en;
    logic [ROW_W-1:0]    row;
    logic                row_last;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output cmd_valid, cmd, abort, mult_cont,
        input  cmd_ready, ld_en, ld_idx, wt_valid, mult_en, row, row_last,
               busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd, abort, mult_cont,
        output cmd_ready, ld_en, ld_idx, wt_valid, mult_en, row, row_last,
               busy, done, err
    );

endinterface

// File: rtl/seq_wrap_counter.sv
// ---------------------------------------------------------------------------
// seq_wrap_counter
// WIDTH-bit up counter that wraps from all-ones to zero.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : force count to 0 next cycle (wins over en)
//   en         : advance by one
//   count      : registered count
//   tc         : registered terminal-count flag, equal to (count == all-ones)
// ---------------------------------------------------------------------------
module seq_wrap_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_next;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (en) begin
            count_next = count + ONE;
        end
    end

    // tc is computed from the next value so it is a flop, yet stays aligned
    // with count.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            tc    <= 1'b0;
        end else begin
            count <= count_next;
            tc    <= &count_next;
        end
    end

endmodule

// File: rtl/ternary_mac_sequencer.sv
// ---------------------------------------------------------------------------
// ternary_mac_sequencer
// Command-driven sequencer for the ternary matrix-vector datapath. Decodes
// 2-bit commands in IDLE and runs bounded weight-load and multiply sequences.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : ternary_mac_sequencer_if.slave (commands in, enables/status out)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module ternary_mac_sequencer
    import ternary_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    ternary_mac_sequencer_if.slave  bus
);

    state_e state;
    state_e state_next;
    logic   load_then_mult;   // remembers LOAD_MULT vs LOAD_ONLY across LOAD
    logic   wt_set;
    logic   wt_clr;
    logic   err_set;
    logic   cmd_take;
    logic   ld_last;
    logic   ld_clear;
    logic   row_clear;

    // Counters are held at 0 whenever their state is not next, so each one
    // starts at 0 on entry and its terminal flag only fires inside its state.
    assign ld_clear  = (state_next != S_LOAD);
    assign row_clear = (state_next != S_MULT);

    // Counters wrap naturally because LD_BEATS and MAX_OUT_LEN are powers of 2.
    seq_wrap_counter #(.WIDTH(LD_IDX_W)) u_ld_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (ld_clear),
        .en    (state == S_LOAD),
        .count (bus.ld_idx),
        .tc    (ld_last)
    );

    seq_wrap_counter #(.WIDTH(ROW_W)) u_row_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (row_clear),
        .en    (state == S_MULT),
        .count (bus.row),
        .tc    (bus.row_last)
    );

    // abort in IDLE also drops a coincident command.
    assign cmd_take = (state == S_IDLE) && bus.cmd_valid && !bus.abort;

    always_comb begin
        state_next = state;
        wt_set     = 1'b0;
        wt_clr     = 1'b0;
        err_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_take) begin
                    case (cmd_e'(bus.cmd))
                        CMD_LOAD_ONLY, CMD_LOAD_MULT: begin
                            state_next = S_LOAD;
                            wt_clr     = 1'b1;   // a partial load never looks valid
                        end
                        CMD_MULT: begin
                            if (bus.wt_valid) begin
                                state_next = S_MULT;
                            end else begin
                                err_set = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_LOAD: begin
                if (bus.abort) begin
                    state_next = S_IDLE;
                end else if (ld_last) begin
                    wt_set     = 1'b1;
                    state_next = load_then_mult ? S_MULT : S_DONE;
                end
            end
            S_MULT: begin
                if (bus.abort) begin
                    state_next = S_IDLE;
                end else if (bus.row_last && !bus.mult_cont) begin
                    state_next = S_DONE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            load_then_mult <= 1'b0;
            bus.cmd_ready  <= 1'b1;
            bus.ld_en      <= 1'b0;
            bus.mult_en    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.wt_valid   <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            state         <= state_next;
            bus.cmd_ready <= (state_next == S_IDLE);
            bus.ld_en     <= (state_next == S_LOAD);
            bus.mult_en   <= (state_next == S_MULT);
            bus.busy      <= (state_next != S_IDLE);
            bus.done      <= (state_next == S_DONE);
            if (cmd_take) begin
                load_then_mult <= (cmd_e'(bus.cmd) == CMD_LOAD_MULT);
            end
            if (wt_clr) begin
                bus.wt_valid <= 1'b0;
            end else if (wt_set) begin
                bus.wt_valid <= 1'b1;
            end
            if (err_set) begin
                bus.err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ternary_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ternary_mac_sequencer
// Each vector holds the inputs applied during one cycle and the outputs
// expected in the following cycle. Expected outputs are queued as inputs are
// driven and popped for comparison once the clock edge has produced them.
// ---------------------------------------------------------------------------
module tb_ternary_mac_sequencer;
    import ternary_pkg::*;

    typedef struct packed {
        logic       rst_n;
        logic       cmd_valid;
        logic [1:0] cmd;
        logic       abort;
        logic       mult_cont;
    } in_t;

    typedef struct packed {
        logic                cmd_ready;
        logic                ld_en;
        logic [LD_IDX_W-1:0] ld_idx;
        logic                wt_valid;
        logic                mult_en;
        logic [ROW_W-1:0]    row;
        logic                row_last;
        logic                busy;
        logic                done;
        logic                err;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic clk;
    logic rst_n;

    ternary_mac_sequencer_if bus ();

    ternary_mac_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t tbl[$];
    out_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // ---------------- expected-output builders ----------------
    function automatic out_t o_idle(input logic wt, input logic er);
        out_t o = '0;
        o.cmd_ready = 1'b1;
        o.wt_valid  = wt;
        o.err       = er;
        return o;
    endfunction

    function automatic out_t o_load(input int idx, input logic er);
        out_t o = '0;
        o.ld_en  = 1'b1;
        o.ld_idx = idx[LD_IDX_W-1:0];
        o.busy   = 1'b1;
        o.err    = er;
        return o;
    endfunction

    function automatic out_t o_mult(input int r, input logic er);
        out_t o = '0;
        o.mult_en  = 1'b1;
        o.row      = r[ROW_W-1:0];
        o.row_last = (r == MAX_OUT_LEN - 1);
        o.busy     = 1'b1;
        o.wt_valid = 1'b1;
        o.err      = er;
        return o;
    endfunction

    function automatic out_t o_done(input logic wt, input logic er);
        out_t o = '0;
        o.busy     = 1'b1;
        o.done     = 1'b1;
        o.wt_valid = wt;
        o.err      = er;
        return o;
    endfunction

    function automatic in_t inp(input logic cv, input logic [1:0] c,
                                input logic ab = 1'b0, input logic mc = 1'b0,
                                input logic rn = 1'b1);
        in_t i;
        i.rst_n     = rn;
        i.cmd_valid = cv;
        i.cmd       = c;
        i.abort     = ab;
        i.mult_cont = mc;
        return i;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("rdy=%b ld_en=%b ld_idx=%0d wt=%b mult_en=%b row=%0d last=%b busy=%b done=%b err=%b",
                         o.cmd_ready, o.ld_en, o.ld_idx, o.wt_valid, o.mult_en,
                         o.row, o.row_last, o.busy, o.done, o.err);
    endfunction

    function automatic out_t sample();
        out_t o;
        o.cmd_ready = bus.cmd_ready;
        o.ld_en     = bus.ld_en;
        o.ld_idx    = bus.ld_idx;
        o.wt_valid  = bus.wt_valid;
        o.mult_en   = bus.mult_en;
        o.row       = bus.row;
        o.row_last  = bus.row_last;
        o.busy      = bus.busy;
        o.done      = bus.done;
        o.err       = bus.err;
        return o;
    endfunction

    // ---------------- table plumbing ----------------
    task automatic add_vec(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        tbl.push_back(v);
    endtask

    task automatic add_reset();
        add_vec(inp(1'b0, CMD_NOP, 1'b0, 1'b0, 1'b0), o_idle(1'b0, 1'b0));
    endtask

    // Command accepted, then the remaining LD_BEATS-1 beats.
    task automatic add_load(input logic [1:0] c, input logic er);
        add_vec(inp(1'b1, c), o_load(0, er));
        for (int k = 1; k < LD_BEATS; k++) begin
            add_vec(inp(1'b0, CMD_NOP), o_load(k, er));
        end
    endtask

    task automatic check(input string name, input int step,
                         input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got {%s} expected {%s}",
                     name, step, fmt(got), fmt(exp));
        end
    endtask

    task automatic run(input string name);
        out_t got;
        out_t exp;
        for (int n = 0; n < tbl.size(); n++) begin
            rst_n         = tbl[n].i.rst_n;
            bus.cmd_valid = tbl[n].i.cmd_valid;
            bus.cmd       = tbl[n].i.cmd;
            bus.abort     = tbl[n].i.abort;
            bus.mult_cont = tbl[n].i.mult_cont;
            exp_q.push_back(tbl[n].o);
            @(posedge clk);
            #1;
            got = sample();
            exp = exp_q.pop_front();
            check(name, n, got, exp);
        end
        tbl.delete();
        rst_n         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd       = CMD_NOP;
        bus.abort     = 1'b0;
        bus.mult_cont = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd       = CMD_NOP;
        bus.abort     = 1'b0;
        bus.mult_cont = 1'b0;

        // 1. Reset, then LOAD_MULT with mult_cont = 0.
        add_reset();
        add_reset();
        add_load(CMD_LOAD_MULT, 1'b0);
        for (int r = 0; r < MAX_OUT_LEN; r++) begin
            add_vec(inp(1'b0, CMD_NOP), o_mult(r, 1'b0));
        end
        add_vec(inp(1'b0, CMD_NOP), o_done(1'b1, 1'b0));
        add_vec(inp(1'b0, CMD_NOP), o_idle(1'b1, 1'b0));
        run("load_mult");

        // 2. MULT straight after reset: err, never busy.
        add_reset();
        add_vec(inp(1'b1, CMD_MULT), o_idle(1'b0, 1'b1));
        add_vec(inp(1'b0, CMD_NOP), o_idle(1'b0, 1'b1));
        add_vec(inp(1'b0, CMD_NOP), o_idle(1'b0, 1'b1));
        run("mult_no_wt");

        // 3. LOAD_ONLY, then three back-to-back MULT passes.
        add_reset();
        add_load(CMD_LOAD_ONLY, 1'b0);
        add_vec(inp(1'b0, CMD_NOP), o_done(1'b1, 1'b0));
        add_vec(inp(1'b1, CMD_LOAD_ONLY), o_idle(1'b1, 1'b0));  // ignored in DONE
        add_vec(inp(1'b1, CMD_MULT, 1'b0, 1'b1), o_mult(0, 1'b0));
        for (int n = 0; n < 3 * MAX_OUT_LEN - 1; n++) begin
            add_vec(inp(1'b0, CMD_NOP, 1'b0, 1'b1), o_mult((n + 1) % MAX_OUT_LEN, 1'b0));
        end
        add_vec(inp(1'b0, CMD_NOP, 1'b0, 1'b0), o_done(1'b1, 1'b0));
        add_vec(inp(1'b0, CMD_NOP), o_idle(1'b1, 1'b0));
        run("mult_passes");

        // 4. abort at load beat 9, then MULT sets err.
        add_reset();
        add_vec(inp(1'b1, CMD_LOAD_ONLY), o_load(0, 1'b0));
        for (int k = 1; k <= 9; k++) begin
            add_vec(inp(1'b0, CMD_NOP), o_load(k, 1'b0));
        end
        add_vec(inp(1'b0, CMD_NOP, 1'b1), o_idle(1'b0, 1'b0));
        add_vec(inp(1'b1, CMD_MULT), o_idle(1'b0, 1'b1));
        add_vec(inp(1'b0, CMD_NOP), o_idle(1'b0, 1'b1));
        run("abort_load");

        // 5. abort on row 7 with mult_cont = 1; abort in IDLE drops a cmd;
        //    abort mid-MULT keeps the weights.
        add_reset();
        add_load(CMD_LOAD_MULT, 1'b0);
        for (int r = 0; r < MAX_OUT_LEN; r++) begin
            add_vec(inp(1'b0, CMD_NOP, 1'b0, 1'b1), o_mult(r, 1'b0));
        end
        add_vec(inp(1'b0, CMD_NOP, 1'b1, 1'b1), o_idle(1'b1, 1'b0));
        add_vec(inp(1'b0, CMD_NOP), o_idle(1'b1, 1'b0));
        add_vec(inp(1'b1, CMD_LOAD_ONLY, 1'b1), o_idle(1'b1, 1'b0));
        add_vec(inp(1'b1, CMD_MULT), o_mult(0, 1'b0));
        add_vec(inp(1'b0, CMD_NOP), o_mult(1, 1'b0));
        add_vec(inp(1'b0, CMD_NOP, 1'b1), o_idle(1'b1, 1'b0));
        run("abort_mult");

        // 6. cmd pulses ignored while busy; rst_n low at row 4.
        add_reset();
        add_vec(inp(1'b1, CMD_LOAD_MULT), o_load(0, 1'b0));
        for (int k = 1; k < LD_BEATS; k++) begin
            add_vec(inp((k % 2) == 1, (k % 3 == 0) ? CMD_LOAD_ONLY : CMD_MULT),
                    o_load(k, 1'b0));
        end
        for (int r = 0; r <= 4; r++) begin
            add_vec(inp((r % 2) == 0, CMD_LOAD_ONLY, 1'b0, 1'b1), o_mult(r, 1'b0));
        end
        add_vec(inp(1'b1, CMD_LOAD_ONLY, 1'b0, 1'b1, 1'b0), o_idle(1'b0, 1'b0));
        add_vec(inp(1'b0, CMD_NOP), o_idle(1'b0, 1'b0));
        run("ignore_and_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
